// File: rtl/decode_queue.sv
// Decode stage feeding a circular queue between fetcher and dispatcher.
// Optional per-entry illegal flag: define DECODE_ILLEGAL_EN to add out_illegal.
module decode_queue #(
    parameter int unsigned DEPTH_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned OP_WIDTH    = 7
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  flush_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OP_WIDTH-1:0]   out_opcode,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [31:0]           out_imm,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_next_pc
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic                  out_illegal
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
    localparam int unsigned CNT_W = DEPTH_WIDTH + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [OP_WIDTH-1:0]   opcode;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [31:0]           imm;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] next_pc;
`ifdef DECODE_ILLEGAL_EN
        logic                  illegal;
`endif
    } entry_t;

    entry_t                 mem_q [DEPTH];
    logic [DEPTH_WIDTH-1:0] head_q;
    logic [DEPTH_WIDTH-1:0] tail_q;
    logic [CNT_W-1:0]       count_q;

    logic [6:0]            opc;
    logic [2:0]            f3;
    logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j, imm_r;
    logic [OP_WIDTH-1:0]   dec_code;
    logic [31:0]           dec_imm;
    logic                  dec_redirect;
    logic [ADDR_WIDTH-1:0] pc_plus4, pc_plus_imm;
    entry_t                dec_entry;
    logic                  push, pop;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];

    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_r = {27'b0, in_inst[24:20]};

    // Opcode/funct3 to internal code; immediate format follows the major opcode
    always_comb begin
        dec_code     = '0;
        dec_imm      = '0;
        dec_redirect = 1'b0;
        case (opc)
            OPC_LUI:   begin dec_code = OP_WIDTH'(1); dec_imm = imm_u; end
            OPC_AUIPC: begin dec_code = OP_WIDTH'(2); dec_imm = imm_u; end
            OPC_JAL: begin
                dec_code     = OP_WIDTH'(3);
                dec_imm      = imm_j;
                dec_redirect = 1'b1;
            end
            OPC_JALR: begin
                dec_imm = imm_i;
                if (f3 == 3'b000) dec_code = OP_WIDTH'(4);
            end
            OPC_BRANCH: begin
                dec_imm      = imm_b;
                dec_redirect = imm_b[31];
                case (f3)
                    3'b000:  dec_code = OP_WIDTH'(5);
                    3'b001:  dec_code = OP_WIDTH'(6);
                    3'b100:  dec_code = OP_WIDTH'(7);
                    3'b101:  dec_code = OP_WIDTH'(8);
                    3'b110:  dec_code = OP_WIDTH'(9);
                    3'b111:  dec_code = OP_WIDTH'(10);
                    default: dec_code = '0;
                endcase
            end
            OPC_LOAD: begin
                dec_imm = imm_i;
                case (f3)
                    3'b000:  dec_code = OP_WIDTH'(11);
                    3'b001:  dec_code = OP_WIDTH'(12);
                    3'b010:  dec_code = OP_WIDTH'(13);
                    3'b100:  dec_code = OP_WIDTH'(14);
                    3'b101:  dec_code = OP_WIDTH'(15);
                    default: dec_code = '0;
                endcase
            end
            OPC_STORE: begin
                dec_imm = imm_s;
                case (f3)
                    3'b000:  dec_code = OP_WIDTH'(16);
                    3'b001:  dec_code = OP_WIDTH'(17);
                    3'b010:  dec_code = OP_WIDTH'(18);
                    default: dec_code = '0;
                endcase
            end
            OPC_OPIMM: begin
                dec_imm = imm_i;
                case (f3)
                    3'b000:  dec_code = OP_WIDTH'(19);
                    3'b010:  dec_code = OP_WIDTH'(20);
                    3'b011:  dec_code = OP_WIDTH'(21);
                    3'b100:  dec_code = OP_WIDTH'(22);
                    3'b110:  dec_code = OP_WIDTH'(23);
                    3'b111:  dec_code = OP_WIDTH'(24);
                    3'b001:  dec_code = OP_WIDTH'(25);
                    default: dec_code = in_inst[30] ? OP_WIDTH'(27) : OP_WIDTH'(26);
                endcase
            end
            OPC_OP: begin
                dec_imm = imm_r;
                case (f3)
                    3'b000:  dec_code = in_inst[30] ? OP_WIDTH'(29) : OP_WIDTH'(28);
                    3'b001:  dec_code = OP_WIDTH'(30);
                    3'b010:  dec_code = OP_WIDTH'(31);
                    3'b011:  dec_code = OP_WIDTH'(32);
                    3'b100:  dec_code = OP_WIDTH'(33);
                    3'b101:  dec_code = in_inst[30] ? OP_WIDTH'(35) : OP_WIDTH'(34);
                    3'b110:  dec_code = OP_WIDTH'(36);
                    default: dec_code = OP_WIDTH'(37);
                endcase
            end
            default: begin
                dec_code = '0;
                dec_imm  = '0;
            end
        endcase
    end

    // Backward branches and jal predict taken; everything else falls through
    assign pc_plus4    = in_pc + ADDR_WIDTH'(4);
    assign pc_plus_imm = in_pc + ADDR_WIDTH'({{ADDR_WIDTH{dec_imm[31]}}, dec_imm});

`ifdef DECODE_ILLEGAL_EN
    logic f7_bad;
    logic dec_illegal;

    always_comb begin
        f7_bad      = (in_inst[31:25] != 7'b0000000) && (in_inst[31:25] != 7'b0100000);
        dec_illegal = (dec_code == '0) || (in_inst[1:0] != 2'b11);
        if (opc == OPC_OP && f7_bad)
            dec_illegal = 1'b1;
        if (opc == OPC_OPIMM && (f3 == 3'b001 || f3 == 3'b101) && f7_bad)
            dec_illegal = 1'b1;
    end
`endif

    always_comb begin
        dec_entry         = '0;
        dec_entry.opcode  = dec_code;
        dec_entry.rs1     = in_inst[19:15];
        dec_entry.rs2     = in_inst[24:20];
        dec_entry.rd      = in_inst[11:7];
        dec_entry.imm     = dec_imm;
        dec_entry.pc      = in_pc;
        dec_entry.next_pc = dec_redirect ? pc_plus_imm : pc_plus4;
`ifdef DECODE_ILLEGAL_EN
        dec_entry.illegal = dec_illegal;
`endif
    end

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Queue state; flush outranks both push and pop
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (flush_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= dec_entry;
                tail_q        <= tail_q + DEPTH_WIDTH'(1);
            end
            if (pop)
                head_q <= head_q + DEPTH_WIDTH'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    assign out_opcode  = mem_q[head_q].opcode;
    assign out_rs1     = mem_q[head_q].rs1;
    assign out_rs2     = mem_q[head_q].rs2;
    assign out_rd      = mem_q[head_q].rd;
    assign out_imm     = mem_q[head_q].imm;
    assign out_pc      = mem_q[head_q].pc;
    assign out_next_pc = mem_q[head_q].next_pc;
`ifdef DECODE_ILLEGAL_EN
    assign out_illegal = mem_q[head_q].illegal;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: queue-based reference model checked every cycle plus pinned literals.
module tb_decode_queue;

    logic        clk_in = 1'b0;
    logic        rst_n_in, flush_in, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_imm, out_pc, out_next_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rs1, out_rs2, out_rd;
`ifdef DECODE_ILLEGAL_EN
    logic        out_illegal;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    decode_queue dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_pc(out_pc), .out_next_pc(out_next_pc)
`ifdef DECODE_ILLEGAL_EN
        , .out_illegal(out_illegal)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          code;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm, pc, next_pc;
        logic        illegal;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set tables
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int bmap[8], lmap[8], smap[8], imap[8], rmap[8];
        logic signed [31:0] s;
        logic [2:0] f3;
        logic f7ok;
        bmap = '{5, 6, 0, 0, 7, 8, 9, 10};
        lmap = '{11, 12, 13, 0, 14, 15, 0, 0};
        smap = '{16, 17, 18, 0, 0, 0, 0, 0};
        imap = '{19, 25, 20, 21, 22, 26, 23, 24};
        rmap = '{28, 30, 31, 32, 33, 34, 36, 37};
        s  = inst;
        f3 = inst[14:12];
        f7ok = (inst[31:25] == 7'h00) || (inst[31:25] == 7'h20);
        e.code = 0;
        e.imm  = 0;
        e.rs1 = inst[19:15];
        e.rs2 = inst[24:20];
        e.rd  = inst[11:7];
        e.pc  = pc;
        case (inst[6:0])
            7'h37: begin e.code = 1; e.imm = inst & 32'hFFFF_F000; end
            7'h17: begin e.code = 2; e.imm = inst & 32'hFFFF_F000; end
            7'h6F: begin e.code = 3; e.imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})); end
            7'h67: begin e.code = (f3 == 0) ? 4 : 0; e.imm = s >>> 20; end
            7'h63: begin e.code = bmap[f3]; e.imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})); end
            7'h03: begin e.code = lmap[f3]; e.imm = s >>> 20; end
            7'h23: begin e.code = smap[f3]; e.imm = 32'($signed({inst[31:25], inst[11:7]})); end
            7'h13: begin
                e.code = imap[f3];
                if (f3 == 5 && inst[30]) e.code = 27;
                e.imm = s >>> 20;
            end
            7'h33: begin
                e.code = rmap[f3];
                if (inst[30] && f3 == 0) e.code = 29;
                if (inst[30] && f3 == 5) e.code = 35;
                e.imm = 32'(inst[24:20]);
            end
            default: ;
        endcase
        if (e.code == 3 || (inst[6:0] == 7'h63 && e.imm[31]))
            e.next_pc = pc + e.imm;
        else
            e.next_pc = pc + 32'd4;
        e.illegal = (e.code == 0) || (inst[1:0] != 2'b11)
                  || (inst[6:0] == 7'h33 && !f7ok)
                  || (inst[6:0] == 7'h13 && (f3 == 1 || f3 == 5) && !f7ok);
        return e;
    endfunction

    // Model state tracks the handshake rules independently of the DUT
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in || flush_in) begin
            q.delete();
        end else begin
            automatic bit do_pop  = out_ready && (q.size() > 0);
            automatic bit do_push = in_valid && (q.size() < 4);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model(in_inst, in_pc));
        end
    end

    always @(negedge clk_in) begin
        chk("in_ready", in_ready, q.size() < 4);
        if (q.size() == 0) begin
            chk("out_valid", out_valid, 0);
        end else begin
            chk("out_valid", out_valid, 1);
            chk("opcode", out_opcode, q[0].code);
            chk("rs1", out_rs1, q[0].rs1);
            chk("rs2", out_rs2, q[0].rs2);
            chk("rd", out_rd, q[0].rd);
            chk("imm", out_imm, q[0].imm);
            chk("pc", out_pc, q[0].pc);
            chk("next_pc", out_next_pc, q[0].next_pc);
`ifdef DECODE_ILLEGAL_EN
            chk("illegal", out_illegal, q[0].illegal);
`endif
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_LUI  = 32'h1234_52B7;
    localparam logic [31:0] I_SW   = 32'h0020_A423;
    localparam logic [31:0] I_LW   = 32'hFFC1_2203;
    localparam logic [31:0] I_SRAI = 32'h4033_D313;
    localparam logic [31:0] I_BNE  = 32'h0020_9463;
    localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;
    localparam logic [31:0] I_BEQ  = 32'hFE00_0CE3;
    localparam logic [31:0] I_JAL  = 32'h0100_00EF;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;

    initial begin
        logic [31:0] fill [4];
        fill = '{I_LUI, I_SW, I_LW, I_SRAI};
        rst_n_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        #2 rst_n_in = 1'b0;
        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_opcode", out_opcode, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_next_pc", out_next_pc, 0);
        rst_n_in = 1'b1;
        tick();

        // single addi, no same-cycle bypass
        offer(I_ADDI, 32'h100);
        chk("no_bypass", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", out_valid, 1);
        chk("addi_code", out_opcode, 19);
        chk("addi_rd", out_rd, 1);
        chk("addi_rs1", out_rs1, 0);
        chk("addi_imm", out_imm, 5);
        chk("addi_next_pc", out_next_pc, 32'h104);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // fill to full, fifth offer ignored, drain in order
        for (int i = 0; i < 4; i++) begin
            offer(fill[i], 32'h400 + 32'(4 * i));
            tick();
        end
        in_valid = 1'b0;
        chk("full_ready", in_ready, 0);
        offer(I_BAD, 32'h410); tick(); in_valid = 1'b0;
        chk("full_head_pc", out_pc, 32'h400);
        out_ready = 1'b1; repeat (4) tick(); out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);

        // full with push offer and pop: pop only, then push+pop across wrap
        for (int i = 0; i < 4; i++) begin
            offer(fill[i], 32'h600 + 32'(4 * i));
            tick();
        end
        offer(I_BNE, 32'h500); out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("full_pop_ready", in_ready, 1);
        chk("full_pop_head", out_pc, 32'h604);
        tick();
        offer(I_BNE, 32'h500); tick();
        offer(I_BAD, 32'h504); tick();
        offer(I_SUB, 32'h508); tick();
        in_valid = 1'b0;
        chk("wrap_head", out_pc, 32'h504);
        chk("wrap_bad_code", out_opcode, 0);
        repeat (2) tick();
        out_ready = 1'b0;
        chk("wrap_empty", out_valid, 0);

        // branch prediction, then async reset at count 3
        offer(I_BEQ, 32'h200); tick();
        offer(I_JAL, 32'h300); tick();
        offer(I_SUB, 32'h010); tick();
        in_valid = 1'b0;
        chk("beq_next_pc", out_next_pc, 32'h1F8);
        #2 rst_n_in = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready, 1);
        tick(); tick();
        rst_n_in = 1'b1;
        offer(I_JAL, 32'h300); tick();
        offer(I_SUB, 32'h010); tick();
        in_valid = 1'b0;
        chk("jal_next_pc", out_next_pc, 32'h310);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("sub_code", out_opcode, 29);

        // flush with a simultaneous push at count 2
        offer(I_ADDI, 32'h020); tick();
        offer(I_LUI, 32'h030); flush_in = 1'b1;
        tick();
        flush_in = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        tick();
        chk("flush_dropped", out_valid, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Registered decode stage with a parametrised buffer, placed between the instruction fetcher and the dispatcher. Each accepted 32-bit instruction and its PC are decoded into the internal opcode code, rs1/rs2/rd, immediate and next-PC, then stored in a circular FIFO. The dispatcher drains the FIFO through a valid/ready handshake. A flush empties the queue on branch mispredict.

Parameters:
DEPTH_WIDTH, 2, log2 of queue depth (DEPTH = 1<<DEPTH_WIDTH entries)
ADDR_WIDTH, 32, PC width
OP_WIDTH, 7, width of internal opcode code

Ports:
clk_in  input  1  clock
rst_n_in  input  1  asynchronous active-low reset
flush_in  input  1  discard all entries and any same-cycle push
in_valid  input  1  fetcher offers an instruction
in_ready  output  1  queue can accept an instruction (count < DEPTH)
in_inst  input  32  raw instruction
in_pc  input  ADDR_WIDTH  instruction PC
out_valid  output  1  head entry present (count != 0)
out_ready  input  1  dispatcher consumes head
out_opcode  output  OP_WIDTH  internal code of head
out_rs1 / out_rs2 / out_rd  output  5 each  register fields of head
out_imm  output  32  decoded immediate of head
out_pc  output  ADDR_WIDTH  head PC
out_next_pc  output  ADDR_WIDTH  predicted next PC of head

Behaviour:
- Reset (asynchronous, rst_n_in low): head=tail=count=0; in_ready=1; out_valid=0; all storage and out_* data outputs are 0.
- Push when in_valid&&in_ready; pop when out_valid&&out_ready. Out_* fields are driven combinationally from the head entry.
- Latency: an instruction pushed in cycle N is visible at out_* in cycle N+1 and cannot bypass to the same cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, in_ready=0 even if a pop occurs this cycle.
- Pointers wrap modulo DEPTH. The count register is DEPTH_WIDTH+1 bits wide.
- flush_in has priority over push and pop. Next cycle: count=0, head=tail=0, out_valid=0.
- Decoding is combinational on in_inst. The result is latched at push.
- Internal opcode codes:
  - lui=1, auipc=2, jal=3, jalr=4.
  - beq,bne,blt,bge,bltu,bgeu = 5..10.
  - lb,lh,lw,lbu,lhu = 11..15.
  - sb,sh,sw = 16..18.
  - addi,slti,sltiu,xori,ori,andi,slli,srli,srai = 19..27.
  - add,sub,sll,slt,sltu,xor,srl,sra,or,and = 28..37.
  - Any unknown opcode or funct3 gives code 0.
- inst[30] selects sub (vs add), sra (vs srl) and srai (vs srli).
- rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], extracted regardless of format.
- Immediate by format:
  - U: {inst[31:12],12'b0}.
  - J: sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - I/L/jalr: sign-extended inst[31:20].
  - S: sign-extended {inst[31:25],inst[11:7]}.
  - B: sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - R: zero-extended inst[24:20].
  - Other: 0.
- next_pc: jal gives pc+imm. B-type gives pc+imm when imm is negative (backward-taken prediction), otherwise pc+4. All other instructions give pc+4. Arithmetic is modulo 2^ADDR_WIDTH.

Optional Feature:
DECODE_ILLEGAL_EN
- Defined: adds output out_illegal (1 bit), stored per entry. It is set when the opcode code is 0 or inst[1:0]!=2'b11. It is also set for R-type funct7 values other than 0000000/0100000, and for slli/srli/srai with inst[31:25] other than 0000000/0100000. Reset value 0.
- Undefined: the port is absent and unknown encodings are queued silently with code 0.

Test Plan:
- Reset with rst_n_in low mid-stream while count=3: out_valid=0, in_ready=1 immediately, before the clock edge.
- Push 0x00500093 (addi x1,x0,5) at pc 0x100, out_ready=0: next cycle out_opcode=19, rd=1, rs1=0, imm=5, next_pc=0x104.
- Push 4 entries with out_ready=0: in_ready=0 after the 4th. Fifth in_valid is ignored. Then pop 4 in order: out_valid falls after the last pop.
- Full queue with simultaneous push offer and pop: only the pop happens and count becomes 3. Then at count 2, push and pop together: count stays 2 and order is preserved across pointer wrap.
- Push beq with imm=-8 at pc 0x200 and jal x1,+16 at pc 0x300: next_pc is 0x1F8 and 0x310 respectively. sub x3,x1,x2 (0x402081B3) gives code 29.
- flush_in asserted together with in_valid at count=2: next cycle out_valid=0 and count=0, and the offered instruction is dropped.
